// File: rtl/uart_byte_source.sv
// 8N1 serial receiver feeding a first-word-fall-through byte FIFO.
// Bytes leave on a data/valid/ready stream; drops are flagged by one-cycle pulses.
module uart_byte_source #(
  parameter int unsigned CLKS_PER_BIT = 2500,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       framing_err
);

  localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic               rx_meta_q, rx_s_q;
  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               push, fe_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   count_q;
  logic               overrun_q, fe_q;
  logic               pop, full, accept;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          timer_d = HALF_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            timer_d = FULL_LOAD;
            bit_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          timer_d = FULL_LOAD;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == '0) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // count never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign full   = count_q[FIFO_AW];
  assign valid  = (count_q != '0);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      fe_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i[FIFO_AW-1:0]] <= '0;
    end else begin
      overrun_q <= push && !accept;
      fe_q      <= fe_d;
      if (accept) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !accept) count_q <= count_q - 1'b1;
    end
  end

  assign data        = mem_q[rd_q];
  assign overrun     = overrun_q;
  assign framing_err = fe_q;

endmodule

// File: tb/tb_uart_byte_source.sv
// Directed bench for uart_byte_source: a queue-level model of the byte stream,
// checked every cycle, plus literal expectations for each scenario.
module tb_uart_byte_source;

  localparam int CPB      = 16;
  localparam int HALF     = CPB / 2;
  // Edges from the rx change to the stop sample: 2 sync flops + 1 detect, half bit, 9 bits.
  localparam int STOP_OFS = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       clr_n, rx, ready;
  logic [7:0] data;
  logic       valid, overrun, framing_err;

  uart_byte_source #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int         errors = 0, checks = 0, cyc = 0;
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         exp_ovr, exp_fe;
  bit         ev_good[int];
  logic [7:0] ev_data[int];
  bit         last_valid = 1'b0;
  logic [7:0] last_data = '0;
  int         n_ovr = 0, n_fe = 0, n_vcyc = 0, vrise_cyc = -1, ready_raise_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 8'hxx;
  endfunction

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    int n;
    bit pop;
    @(posedge clk);
    n   = mq.size();
    pop = (n != 0) && (ready === 1'b1);
    if (last_valid && ready === 1'b1) got.push_back(last_data);
    cyc++;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    if (!clr_n) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (ev_good.exists(cyc)) begin
        if (!ev_good[cyc])          exp_fe = 1'b1;
        else if (n < 16 || pop)     mq.push_back(ev_data[cyc]);
        else                        exp_ovr = 1'b1;
      end
    end
    @(negedge clk);
    if (!clr_n) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_framing", 32'(framing_err), 32'd0);
    end else begin
      chk("valid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("data", 32'(data), 32'(mq[0]));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("framing_err", 32'(framing_err), 32'(exp_fe));
      chk("count", 32'(dut.count_q), 32'(mq.size()));
    end
    if (valid === 1'b1 && !last_valid) vrise_cyc = cyc;
    last_valid = (valid === 1'b1);
    last_data  = data;
    n_ovr  += (overrun === 1'b1) ? 1 : 0;
    n_fe   += (framing_err === 1'b1) ? 1 : 0;
    n_vcyc += (valid === 1'b1) ? 1 : 0;
    if (cyc == ready_raise_at - 1) ready = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int e0);
    logic [9:0] bits;
    e0 = cyc;
    ev_good[e0 + STOP_OFS] = stop_ok;
    ev_data[e0 + STOP_OFS] = b;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) tick();
    end
    rx = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int e0, base, fe0, ov0, vc0;
    clr_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
    repeat (4) tick();

    // Single byte with ready high: valid for exactly one cycle.
    ready = 1'b1;
    vc0   = n_vcyc;
    base  = got.size();
    send_frame(8'h41, 1'b1, e0);
    repeat (4) tick();
    chk("t1_rise", 32'(vrise_cyc - e0), 32'd155);
    chk("t1_vcycles", 32'(n_vcyc - vc0), 32'd1);
    chk("t1_npop", 32'(got.size() - base), 32'd1);
    chk("t1_byte", 32'(got_at(base)), 32'h41);

    // Backpressure, hold, then alternating ready.
    ready = 1'b0;
    base  = got.size();
    send_frame(8'h1B, 1'b1, e0);
    send_frame(8'h59, 1'b1, e0);
    send_frame(8'h20, 1'b1, e0);
    chk("t2_count", 32'(dut.count_q), 32'd3);
    chk("t2_head", 32'(data), 32'h1B);
    repeat (5) tick();
    chk("t2_hold", 32'(data), 32'h1B);
    for (int i = 0; i < 12; i++) begin
      ready = ~ready;
      tick();
    end
    chk("t2_npop", 32'(got.size() - base), 32'd3);
    chk("t2_b0", 32'(got_at(base)), 32'h1B);
    chk("t2_b1", 32'(got_at(base + 1)), 32'h59);
    chk("t2_b2", 32'(got_at(base + 2)), 32'h20);
    chk("t2_empty", 32'(valid), 32'd0);

    // Seventeen bytes into a 16-deep FIFO with no consumer.
    ready = 1'b0;
    ov0   = n_ovr;
    base  = got.size();
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, e0);
    chk("t3_overruns", 32'(n_ovr - ov0), 32'd1);
    ready = 1'b1;
    repeat (20) tick();
    chk("t3_npop", 32'(got.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) chk("t3_drain", 32'(got_at(base + i)), 32'(i));

    // Full FIFO with a pop landing on the stop-sample edge of byte 17.
    ready = 1'b0;
    ov0   = n_ovr;
    base  = got.size();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, e0);
    ready_raise_at = cyc + STOP_OFS;
    send_frame(8'h10, 1'b1, e0);
    ready_raise_at = -1;
    repeat (20) tick();
    chk("t4_overruns", 32'(n_ovr - ov0), 32'd0);
    chk("t4_npop", 32'(got.size() - base), 32'd17);
    chk("t4_first", 32'(got_at(base)), 32'h00);
    for (int i = 0; i < 16; i++) chk("t4_drain", 32'(got_at(base + 1 + i)), 32'(i + 1));

    // Low stop bit.
    fe0  = n_fe;
    base = got.size();
    send_frame(8'h55, 1'b0, e0);
    repeat (4) tick();
    chk("t5_fe", 32'(n_fe - fe0), 32'd1);
    chk("t5_nopush", 32'(got.size() - base), 32'd0);

    // Line held low for 40 bit times, then a clean byte.
    fe0 = n_fe;
    rx  = 1'b0;
    e0  = cyc;
    ev_good[e0 + STOP_OFS] = 1'b0;
    ev_data[e0 + STOP_OFS] = 8'h00;
    repeat (40 * CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    chk("t5_break_fe", 32'(n_fe - fe0), 32'd1);
    base = got.size();
    send_frame(8'h0D, 1'b1, e0);
    repeat (4) tick();
    chk("t5_after_break", 32'(got_at(base)), 32'h0D);

    // Three-cycle glitch.
    fe0 = n_fe;
    ov0 = n_ovr;
    vc0 = n_vcyc;
    rx  = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
    chk("t5_glitch_fe", 32'(n_fe - fe0), 32'd0);
    chk("t5_glitch_ovr", 32'(n_ovr - ov0), 32'd0);
    chk("t5_glitch_valid", 32'(n_vcyc - vc0), 32'd0);

    // Reset during data bit 4 of 0xFF.
    vc0 = n_vcyc;
    rx  = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB + HALF) tick();
    clr_n = 1'b0;
    repeat (3) tick();
    chk("t6_rst_valid", 32'(valid), 32'd0);
    clr_n = 1'b1;
    repeat (4 * CPB) tick();
    chk("t6_novalid", 32'(n_vcyc - vc0), 32'd0);
    base = got.size();
    send_frame(8'h0A, 1'b1, e0);
    repeat (4) tick();
    chk("t6_npop", 32'(got.size() - base), 32'd1);
    chk("t6_byte", 32'(got_at(base)), 32'h0A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
